mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/sat_counter32.sv | 25 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the single-port memory arbiter between the
// fetch (IF) and memory (MEM) stages.
package mips_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    localparam logic [31:0] STALL_SAT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM_CMD,
        ST_MEM_WAIT,
        ST_IF_CMD,
        ST_IF_WAIT,
        ST_ADVANCE
    } arb_state_e;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter32
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != STALL_SAT)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// stalling the pipeline until every access latched in IDLE has completed.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    output logic [DATA_W-1:0] IF_Data,
    output logic              IF_Valid,
    input  logic              MEM_Req,
    input  logic              MEM_Write,
    input  logic [ADDR_W-1:0] MEM_Addr,
    input  logic [DATA_W-1:0] MEM_WData,
    output logic [DATA_W-1:0] MEM_RData,
    output logic              MEM_Valid,
    output logic              Cmd_Valid,
    output logic              Cmd_Write,
    output logic [ADDR_W-1:0] Cmd_Addr,
    output logic [DATA_W-1:0] Cmd_WData,
    input  logic              Cmd_Ready,
    input  logic              Rsp_Valid,
    input  logic [DATA_W-1:0] Rsp_Data,
    output logic              PC_Enable,
    output logic              IF_ID_Pipeline_Enable,
    output logic              Back_Stall,
    output logic [31:0]       Stall_Cycles
);

    arb_state_e        state_q, state_next;
    logic              need_if_q, need_mem_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q, if_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_data_q, mem_rdata_q;
    logic              stall;
    logic              start;

    // Requests are sampled only when leaving IDLE; the pipeline may change them later.
    assign start = (state_q == ST_IDLE) && (IF_Req || MEM_Req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // NOTE: the latched request fields and capture registers are reset as well;
    // they drive outputs directly and must read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            need_if_q   <= 1'b0;
            need_mem_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_addr_q   <= '0;
        end else if (start) begin
            need_if_q   <= IF_Req;
            need_mem_q  <= MEM_Req;
            mem_write_q <= MEM_Write;
            mem_addr_q  <= MEM_Addr;
            mem_wdata_q <= MEM_WData;
            if_addr_q   <= IF_Addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            if ((state_q == ST_MEM_WAIT) && Rsp_Valid && !mem_write_q) begin
                mem_rdata_q <= Rsp_Data;
            end
            if ((state_q == ST_IF_WAIT) && Rsp_Valid) begin
                if_data_q <= Rsp_Data;
            end
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state_q;
        Cmd_Valid  = 1'b0;
        Cmd_Write  = 1'b0;
        Cmd_Addr   = mem_addr_q;
        Cmd_WData  = mem_wdata_q;
        IF_Valid   = 1'b0;
        MEM_Valid  = 1'b0;
        stall      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                stall = IF_Req || MEM_Req;
                if (MEM_Req) begin
                    state_next = ST_MEM_CMD;
                end else if (IF_Req) begin
                    state_next = ST_IF_CMD;
                end
            end
            ST_MEM_CMD: begin
                Cmd_Valid = 1'b1;
                Cmd_Write = mem_write_q;
                if (Cmd_Ready) begin
                    state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (Rsp_Valid) begin
                    state_next = need_if_q ? ST_IF_CMD : ST_ADVANCE;
                end
            end
            ST_IF_CMD: begin
                Cmd_Valid = 1'b1;
                Cmd_Addr  = if_addr_q;
                if (Cmd_Ready) begin
                    state_next = ST_IF_WAIT;
                end
            end
            ST_IF_WAIT: begin
                if (Rsp_Valid) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                stall      = 1'b0;
                IF_Valid   = need_if_q;
                MEM_Valid  = need_mem_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign PC_Enable             = !stall;
    assign IF_ID_Pipeline_Enable = !stall;
    assign Back_Stall            = stall;
    assign IF_Data               = if_data_q;
    assign MEM_RData             = mem_rdata_q;

    sat_counter32 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (Stall_Cycles)
    );

endmodule
